ldl_bin2hot_pipe: RTL and testbench
===================================

LDL_BIN2HOT_PIPE -- requirements
Module: LDL_bin2hot_pipe

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 4, binary index width.
REQ-002 SHALL have parameter HOT_WIDTH, default (1 << BIN_WIDTH), one-hot output width; legal range 1..(1 << BIN_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port x_valid  input  1  input transfer request.
REQ-006 SHALL have port x_ready  output  1  input can accept.
REQ-007 SHALL have port x  input  BIN_WIDTH  binary index.
REQ-008 SHALL have port therm  input  1  sampled with x; 1 = thermometer encoding, 0 = one-hot.
REQ-009 SHALL have port y_valid  output  1  output holds a decoded word.
REQ-010 SHALL have port y_ready  input  1  downstream accepts.
REQ-011 SHALL have port y  output  HOT_WIDTH  decoded vector.
REQ-012 SHALL have port y_err  output  1  index was out of range (x >= HOT_WIDTH).

Function
REQ-013 Input transfer SHALL occur on a rising edge with x_valid && x_ready; output transfer on a rising edge with y_valid && y_ready.
REQ-014 One-hot decode: y[j] = (j == x) for j in 0..HOT_WIDTH-1.
REQ-015 Thermometer decode: y[j] = (j <= x); x = 0 gives y = 1.
REQ-016 x >= HOT_WIDTH: y = all zeros, y_err = 1, in both modes; otherwise y_err = 0.
REQ-017 Latency SHALL be exactly 1 cycle: word accepted at edge N is on y with y_valid = 1 after edge N when the output register is empty or drains at edge N.
REQ-018 While y_valid && !y_ready, y, y_err and y_valid SHALL hold stable.
REQ-019 Words SHALL leave in acceptance order; none dropped, none duplicated.
REQ-020 Simultaneous input and output transfer at one edge SHALL load the new word into the output register, y_valid staying 1 (full throughput, 1 word/cycle).
REQ-021 Output drained with no new input SHALL clear y_valid at that edge; y keeps its last value (don't-care for the checker).
REQ-022 x and therm SHALL be ignored when no input transfer occurs.

Reset
REQ-023 rst_n low SHALL asynchronously clear y_valid = 0, y = 0, y_err = 0 and discard every held word, including mid-stall.
REQ-024 After rst_n deasserts, the first input transfer SHALL be possible at the first rising edge.

Configuration
REQ-025 Macro LDL_BIN2HOT_SKID_EN SHALL select the ready-path structure.
REQ-026 Without LDL_BIN2HOT_SKID_EN: x_ready = !y_valid || y_ready (combinational from y_ready); no extra storage; x_ready = 1 during reset.
REQ-027 With LDL_BIN2HOT_SKID_EN: x_ready SHALL be a flop, reset to 1, equal to "skid register empty"; no combinational path y_ready -> x_ready.
REQ-028 With skid: input accepted while output stalls SHALL be decoded into the skid register; at the next output transfer the skid word SHALL move to the output register and x_ready SHALL return to 1 the following cycle.
REQ-029 With skid: throughput SHALL remain 1 word/cycle with y_ready held 1, latency 1 cycle, order preserved; reset SHALL also clear the skid register.

Verification
REQ-030 BIN_WIDTH=4, y_ready=1, x=5, therm=0, one transfer -> next cycle y=16'h0020, y_err=0, y_valid=1; following cycle y_valid=0.
REQ-031 x=3, therm=1 -> y=16'h000F; x=15, therm=1 -> y=16'hFFFF.
REQ-032 HOT_WIDTH=10, x=12 -> y=10'h000, y_err=1; x=9 -> y=10'h200, y_err=0.
REQ-033 Back-to-back x=0,1,2,3 with y_ready toggling 1,0,1,0,... -> outputs 0001,0002,0004,0008 in order, each held while stalled; with SKID_EN, x_ready never depends combinationally on y_ready.
REQ-034 Stall y_ready=0 with a word held (plus a skid word if enabled), pulse rst_n low between edges -> y_valid=0, y=0, y_err=0 immediately; no stale word after release.
REQ-035 Random x/therm/valid/ready for 10k cycles against a reference queue model -> zero mismatches, both macro settings.

Source files
------------

// File: rtl/ldl_bin2hot_pipe.sv
// Binary index to one-hot/thermometer decoder behind a valid/ready register stage.
// LDL_BIN2HOT_SKID_EN adds a skid register so x_ready is a flop with no path from y_ready.
module ldl_bin2hot_pipe #(
    parameter int BIN_WIDTH = 4,
    parameter int HOT_WIDTH = (1 << BIN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [BIN_WIDTH-1:0] x,
    input  logic                 therm,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [HOT_WIDTH-1:0] y,
    output logic                 y_err
);

    localparam logic [BIN_WIDTH:0] HOT_LIM = (BIN_WIDTH + 1)'(HOT_WIDTH);

    logic [HOT_WIDTH-1:0] dec_y;
    logic                 dec_err;
    logic                 in_fire;

    always_comb begin
        dec_err = ({1'b0, x} >= HOT_LIM);
        dec_y   = '0;
        for (int j = 0; j < HOT_WIDTH; j++) begin
            if (therm) dec_y[j] = (BIN_WIDTH'(j) <= x);
            else       dec_y[j] = (BIN_WIDTH'(j) == x);
        end
        if (dec_err) dec_y = '0;
    end

`ifdef LDL_BIN2HOT_SKID_EN

    logic                 rdy_q;
    logic                 s_valid;
    logic [HOT_WIDTH-1:0] s_y;
    logic                 s_err;
    logic                 out_open;

    assign x_ready  = rdy_q;
    assign in_fire  = x_valid && rdy_q;
    assign out_open = !y_valid || y_ready;

    // rdy_q always mirrors !s_valid; a held skid word blocks new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b1;
            s_valid <= 1'b0;
            s_y     <= '0;
            s_err   <= 1'b0;
            y_valid <= 1'b0;
            y       <= '0;
            y_err   <= 1'b0;
        end else if (out_open) begin
            if (s_valid) begin
                y       <= s_y;
                y_err   <= s_err;
                y_valid <= 1'b1;
                s_valid <= 1'b0;
                rdy_q   <= 1'b1;
            end else if (in_fire) begin
                y       <= dec_y;
                y_err   <= dec_err;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_y     <= dec_y;
            s_err   <= dec_err;
            s_valid <= 1'b1;
            rdy_q   <= 1'b0;
        end
    end

`else

    assign x_ready = !y_valid || y_ready;
    assign in_fire = x_valid && x_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y       <= '0;
            y_err   <= 1'b0;
        end else if (in_fire) begin
            y       <= dec_y;
            y_err   <= dec_err;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_ldl_bin2hot_pipe.sv
// Self-checking bench for ldl_bin2hot_pipe: a 16-wide and a 10-wide instance share stimulus.
// Directed table, handshake sequences, reset mid-stall and a queue-model random run.
module tb_ldl_bin2hot_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_valid = 1'b0;
    logic [3:0]  x = '0;
    logic        therm = 1'b0;
    logic        y_ready = 1'b0;

    logic        xa_ready, ya_valid, ya_err;
    logic [15:0] ya;
    logic        xb_ready, yb_valid, yb_err;
    logic [9:0]  yb;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ldl_bin2hot_pipe #(.BIN_WIDTH(4), .HOT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xa_ready),
        .x(x), .therm(therm), .y_valid(ya_valid), .y_ready(y_ready),
        .y(ya), .y_err(ya_err)
    );

    ldl_bin2hot_pipe #(.BIN_WIDTH(4), .HOT_WIDTH(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xb_ready),
        .x(x), .therm(therm), .y_valid(yb_valid), .y_ready(y_ready),
        .y(yb), .y_err(yb_err)
    );

    typedef struct {
        logic [3:0]  x;
        logic        t;
        logic [15:0] ya;
        logic        ea;
        logic [9:0]  yb;
        logic        eb;
    } vec_t;

    vec_t vt[11];

    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [15:0] outs_a[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {err, word} for an index decoded at width w
    function automatic logic [16:0] model(logic [3:0] xv, logic t, int w);
        logic [31:0] v;
        if (int'(xv) >= w) return 17'h10000;
        v = t ? ((32'd2 << xv) - 32'd1) : (32'd1 << xv);
        return {1'b0, v[15:0]};
    endfunction

    // One cycle of scoreboard checking; inputs already driven at the negedge
    logic        pa, pb;
    logic [16:0] ha, hb;

    task automatic sb_cycle();
        logic fa, fb;
        logic [16:0] e;
        #1;
        if (pa) begin
            chk("a_hold_valid", 32'(ya_valid), 32'd1);
            chk("a_hold_word", 32'({ya_err, ya}), 32'(ha));
        end
        if (pb) begin
            chk("b_hold_valid", 32'(yb_valid), 32'd1);
            chk("b_hold_word", 32'({yb_err, 6'd0, yb}), 32'(hb));
        end
        if (ya_valid && y_ready) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'(ya_valid), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_out_word", 32'({ya_err, ya}), 32'(e));
                outs_a.push_back(ya);
            end
        end
        if (yb_valid && y_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(yb_valid), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_out_word", 32'({yb_err, 6'd0, yb}), 32'({e[16], 6'd0, e[9:0]}));
            end
        end
        pa = ya_valid && !y_ready;
        pb = yb_valid && !y_ready;
        ha = {ya_err, ya};
        hb = {yb_err, 6'd0, yb};
        fa = x_valid && xa_ready;
        fb = x_valid && xb_ready;
        @(posedge clk);
        if (fa) qa.push_back(model(x, therm, 16));
        if (fb) qb.push_back(model(x, therm, 10));
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        x_valid = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            y_ready = 1'b1;
            sb_cycle();
            n++;
        end
        chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        int idx;
        logic r0;

        vt[0]  = '{4'd5,  1'b0, 16'h0020, 1'b0, 10'h020, 1'b0};
        vt[1]  = '{4'd3,  1'b1, 16'h000F, 1'b0, 10'h00F, 1'b0};
        vt[2]  = '{4'd15, 1'b1, 16'hFFFF, 1'b0, 10'h000, 1'b1};
        vt[3]  = '{4'd0,  1'b1, 16'h0001, 1'b0, 10'h001, 1'b0};
        vt[4]  = '{4'd0,  1'b0, 16'h0001, 1'b0, 10'h001, 1'b0};
        vt[5]  = '{4'd12, 1'b0, 16'h1000, 1'b0, 10'h000, 1'b1};
        vt[6]  = '{4'd9,  1'b0, 16'h0200, 1'b0, 10'h200, 1'b0};
        vt[7]  = '{4'd9,  1'b1, 16'h03FF, 1'b0, 10'h3FF, 1'b0};
        vt[8]  = '{4'd10, 1'b0, 16'h0400, 1'b0, 10'h000, 1'b1};
        vt[9]  = '{4'd15, 1'b0, 16'h8000, 1'b0, 10'h000, 1'b1};
        vt[10] = '{4'd12, 1'b1, 16'h1FFF, 1'b0, 10'h000, 1'b1};

        #1;
        chk("rst_y_valid", 32'(ya_valid), 32'd0);
        chk("rst_y", 32'(ya), 32'd0);
        chk("rst_y_err", 32'(ya_err), 32'd0);
        chk("rst_x_ready", 32'(xa_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfers with y_ready held high
        foreach (vt[i]) begin
            y_ready = 1'b1;
            x_valid = 1'b1;
            x = vt[i].x;
            therm = vt[i].t;
            @(posedge clk);
            @(negedge clk);
            x_valid = 1'b0;
            x = ~vt[i].x;
            therm = ~vt[i].t;
            #1;
            chk($sformatf("v%0d_a_valid", i), 32'(ya_valid), 32'd1);
            chk($sformatf("v%0d_a_y", i), 32'(ya), 32'(vt[i].ya));
            chk($sformatf("v%0d_a_err", i), 32'(ya_err), 32'(vt[i].ea));
            chk($sformatf("v%0d_b_y", i), 32'(yb), 32'(vt[i].yb));
            chk($sformatf("v%0d_b_err", i), 32'(yb_err), 32'(vt[i].eb));
            @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_a_empty", i), 32'(ya_valid), 32'd0);
            @(negedge clk);
        end

        // Back-to-back 0..3 with y_ready toggling 1,0,1,0
        pa = 1'b0; pb = 1'b0;
        outs_a.delete();
        idx = 0;
        for (int c = 0; c < 40 && outs_a.size() < 4; c++) begin
            y_ready = (c % 2 == 0);
            x_valid = (idx < 4);
            x = 4'(idx);
            therm = 1'b0;
`ifdef LDL_BIN2HOT_SKID_EN
            #1;
            r0 = xa_ready;
            y_ready = ~y_ready;
            #1;
            chk("skid_ready_comb", 32'(xa_ready), 32'(r0));
            y_ready = ~y_ready;
`endif
            if (x_valid) begin
                #1;
                if (xa_ready) idx++;
                #0;
            end
            sb_cycle();
        end
        drain();
        chk("seq_count", 32'(outs_a.size()), 32'd4);
        if (outs_a.size() == 4) begin
            chk("seq_0", 32'(outs_a[0]), 32'h0001);
            chk("seq_1", 32'(outs_a[1]), 32'h0002);
            chk("seq_2", 32'(outs_a[2]), 32'h0004);
            chk("seq_3", 32'(outs_a[3]), 32'h0008);
        end

        // Reset pulse between edges while stalled
        y_ready = 1'b0;
        x_valid = 1'b1; x = 4'd7; therm = 1'b1;
        @(posedge clk); @(negedge clk);
        x = 4'd3; therm = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("stall_a_y", 32'(ya), 32'h00FF);
        x_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(ya_valid), 32'd0);
        chk("mid_rst_a_y", 32'(ya), 32'd0);
        chk("mid_rst_a_err", 32'(ya_err), 32'd0);
        chk("mid_rst_b_y", 32'(yb), 32'd0);
        chk("mid_rst_x_ready", 32'(xa_ready), 32'd1);
        x_valid = 1'b1; x = 4'd2; therm = 1'b0; y_ready = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        x_valid = 1'b0;
        #1;
        chk("post_rst_first_valid", 32'(ya_valid), 32'd1);
        chk("post_rst_first_y", 32'(ya), 32'h0004);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_stale", 32'(ya_valid), 32'd0);
        end
        @(negedge clk);

        // Random traffic against the queue model
        qa.delete(); qb.delete();
        pa = 1'b0; pb = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            x_valid = 1'($urandom_range(0, 1));
            x = 4'($urandom_range(0, 15));
            therm = 1'($urandom_range(0, 1));
            y_ready = ($urandom_range(0, 3) != 0);
            sb_cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
